hex_display_ctrl: RTL

Sequencing controller for the board's seven-segment bank. It accepts a packed hex value plus per-digit blank mask from the I/O write path and time-shares a single `decoder_hex` instance across all digits, one digit per cycle. It applies optional leading-zero suppression and commits all digit patterns to the output register on one clock edge, so the display never shows a partially updated value. It sits between the LSU's output-peripheral registers and the HEX pins.

---
 rtl/hex_display_ctrl_if.sv | 36 +++
 rtl/hex_display_ctrl.sv | 129 ++++++++++++
 2 files changed

// File: rtl/hex_display_ctrl_if.sv
// Write-path bundle between the LSU output-peripheral registers and the
// seven-segment sequencing controller.
interface hex_display_ctrl_if #(
    parameter int NUM_DIGITS = 8
);
    logic                    wr_valid;
    logic                    wr_ready;
    logic [4*NUM_DIGITS-1:0] wr_data;
    logic [NUM_DIGITS-1:0]   blank_mask;
    logic                    lz_en;
    logic [7*NUM_DIGITS-1:0] hex;
    logic                    busy;
    logic                    done;

    modport master (
        output wr_valid,
        output wr_data,
        output blank_mask,
        output lz_en,
        input  wr_ready,
        input  hex,
        input  busy,
        input  done
    );

    modport slave (
        input  wr_valid,
        input  wr_data,
        input  blank_mask,
        input  lz_en,
        output wr_ready,
        output hex,
        output busy,
        output done
    );
endinterface

// File: rtl/hex_display_ctrl.sv
// Seven-segment bank controller: scans one digit per cycle through a single
// shared hex decoder and commits the whole bank to the pins on one edge.
module hex_display_ctrl #(
    parameter int NUM_DIGITS = 8
) (
    input  logic               i_clk,
    input  logic               i_reset,
    hex_display_ctrl_if.slave  bus
);
    localparam int         IDX_W = $clog2(NUM_DIGITS);
    localparam logic [6:0] BLANK = 7'h7F;

    typedef enum logic {IDLE, SCAN} state_t;

    state_t                  state, state_n;
    logic [4*NUM_DIGITS-1:0] shadow_data, shadow_data_n;
    logic [NUM_DIGITS-1:0]   shadow_mask, shadow_mask_n;
    logic                    shadow_lz, shadow_lz_n;
    logic [IDX_W-1:0]        idx, idx_n;
    logic                    seen_nz, seen_nz_n;
    logic [7*NUM_DIGITS-1:0] staging, staging_n;
    logic [7*NUM_DIGITS-1:0] hex_q, hex_n;
    logic                    done_q, done_n;
    logic [3:0]              nibble;
    logic [6:0]              seg;
    logic [6:0]              pattern;

    assign nibble = shadow_data[idx*4 +: 4];

    // The one decoder shared by every digit; active-low gfedcba.
    always_comb begin
        seg = BLANK;
        case (nibble)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
            default: seg = BLANK;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state       <= IDLE;
            shadow_data <= '0;
            shadow_mask <= '0;
            shadow_lz   <= 1'b0;
            idx         <= '0;
            seen_nz     <= 1'b0;
            staging     <= {NUM_DIGITS{BLANK}};
            hex_q       <= {NUM_DIGITS{BLANK}};
            done_q      <= 1'b0;
        end else begin
            state       <= state_n;
            shadow_data <= shadow_data_n;
            shadow_mask <= shadow_mask_n;
            shadow_lz   <= shadow_lz_n;
            idx         <= idx_n;
            seen_nz     <= seen_nz_n;
            staging     <= staging_n;
            hex_q       <= hex_n;
            done_q      <= done_n;
        end
    end

    // Scan runs from the top digit down so leading zeros are known to be
    // leading by the time they are reached; digit 0 is never LZ-suppressed.
    always_comb begin
        state_n       = state;
        shadow_data_n = shadow_data;
        shadow_mask_n = shadow_mask;
        shadow_lz_n   = shadow_lz;
        idx_n         = idx;
        seen_nz_n     = seen_nz;
        staging_n     = staging;
        hex_n         = hex_q;
        done_n        = 1'b0;
        pattern       = BLANK;

        case (state)
            IDLE: begin
                if (bus.wr_valid) begin
                    shadow_data_n = bus.wr_data;
                    shadow_mask_n = bus.blank_mask;
                    shadow_lz_n   = bus.lz_en;
                    idx_n         = IDX_W'(NUM_DIGITS - 1);
                    seen_nz_n     = 1'b0;
                    state_n       = SCAN;
                end
            end
            SCAN: begin
                if (shadow_mask[idx]) begin
                    pattern = BLANK;
                end else if (shadow_lz && !seen_nz && nibble == 4'h0 && idx != '0) begin
                    pattern = BLANK;
                end else begin
                    pattern   = seg;
                    seen_nz_n = 1'b1;
                end
                staging_n[idx*7 +: 7] = pattern;
                if (idx == '0) begin
                    hex_n   = staging_n;
                    state_n = IDLE;
                    done_n  = 1'b1;
                end else begin
                    idx_n = idx - IDX_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.wr_ready = (state == IDLE);
    assign bus.busy     = (state == SCAN);
    assign bus.hex      = hex_q;
    assign bus.done     = done_q;
endmodule
